// File: rtl/mux_path_scheduler_if.sv
// ---------------------------------------------------------------------------
// mux_path_scheduler_if
// Bundle between the requester side and the mux/demux path scheduler.
//   enable     : scheduler run enable                       (master -> slave)
//   req[7:0]   : per-requester path request                 (master -> slave)
//   dest[15:0] : 2-bit demux destination per requester      (master -> slave)
//   dwell      : hold length in cycles, 0 behaves as 1      (master -> slave)
//   s_mux      : registered mux select                      (slave -> master)
//   s_demux    : registered demux select                    (slave -> master)
//   grant[7:0] : one-hot grant, 0 when idle                 (slave -> master)
//   path_valid : path settled and owned                     (slave -> master)
// ---------------------------------------------------------------------------
interface mux_path_scheduler_if #(
    parameter int DWELL_W = 16
);
    logic               enable;
    logic [7:0]         req;
    logic [15:0]        dest;
    logic [DWELL_W-1:0] dwell;
    logic [2:0]         s_mux;
    logic [1:0]         s_demux;
    logic [7:0]         grant;
    logic               path_valid;

    modport master (
        output enable, req, dest, dwell,
        input  s_mux, s_demux, grant, path_valid
    );

    modport slave (
        input  enable, req, dest, dwell,
        output s_mux, s_demux, grant, path_valid
    );
endinterface

// File: rtl/mux_path_scheduler.sv
// ---------------------------------------------------------------------------
// mux_path_scheduler
// Round-robin owner of the 8:1 mux / 1:4 demux test path. One requester at a
// time gets the path for a sampled dwell; every select change is followed by
// a guard interval with path_valid low (break-before-make).
// Ports:
//   clk     : system clock, rising edge
//   reset_n : asynchronous active-low reset
//   bus     : mux_path_scheduler_if.slave (enable/req/dest/dwell in,
//             s_mux/s_demux/grant/path_valid out)
// ---------------------------------------------------------------------------
module mux_path_scheduler #(
    parameter int DWELL_W   = 16,
    parameter int GUARD_CYC = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    mux_path_scheduler_if.slave  bus
);
    localparam int GW = (GUARD_CYC < 2) ? 1 : $clog2(GUARD_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GUARD = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t             r_state,     w_state_next;
    logic [2:0]         r_last,      w_last_next;
    logic [2:0]         r_s_mux,     w_s_mux_next;
    logic [1:0]         r_s_demux,   w_s_demux_next;
    logic [7:0]         r_grant,     w_grant_next;
    logic [DWELL_W-1:0] r_dwell_cnt, w_dwell_next;
    logic [GW-1:0]      r_guard_cnt, w_guard_next;

    // Arbitration. At the end of a hold the pointer that applies is the
    // current winner (it becomes 'last' on that same edge), so the search
    // base is taken from s_mux while in HOLD and from r_last otherwise.
    logic [2:0]         w_base;
    logic [2:0]         w_cand [8];
    logic [7:0]         w_cand_req;
    logic               w_found;
    logic [2:0]         w_winner;
    logic [1:0]         w_dest_sel;
    logic [DWELL_W-1:0] w_dwell_load;
    logic               w_arb;

    assign w_base = (r_state == S_HOLD) ? r_s_mux : r_last;

    // Candidate gi is the (gi+1)-th requester after the base, wrapping mod 8;
    // the last candidate is the base itself.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cand
            assign w_cand[gi]     = w_base + 3'(gi + 1);
            assign w_cand_req[gi] = bus.req[w_cand[gi]];
        end
    endgenerate

    always_comb begin
        w_found  = |w_cand_req;
        w_winner = w_cand[0];
        // Walk from farthest to nearest so the nearest set request wins.
        for (int k = 7; k >= 0; k--) begin
            if (w_cand_req[k]) begin
                w_winner = w_cand[k];
            end
        end
    end

    assign w_dest_sel   = bus.dest[{w_winner, 1'b0} +: 2];
    assign w_dwell_load = (bus.dwell == '0) ? DWELL_W'(1) : bus.dwell;

    // Next-state and next-register logic.
    always_comb begin
        w_state_next   = r_state;
        w_last_next    = r_last;
        w_s_mux_next   = r_s_mux;
        w_s_demux_next = r_s_demux;
        w_grant_next   = r_grant;
        w_dwell_next   = r_dwell_cnt;
        w_guard_next   = r_guard_cnt;
        w_arb          = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_grant_next = '0;
                if (bus.enable && w_found) begin
                    w_arb = 1'b1;
                end
            end
            S_GUARD: begin
                // Abandoned before the path was ever owned: pointer untouched.
                if (!bus.enable || !bus.req[r_s_mux]) begin
                    w_state_next = S_IDLE;
                    w_grant_next = '0;
                end else if (r_guard_cnt <= GW'(1)) begin
                    w_state_next = S_HOLD;
                end else begin
                    w_guard_next = r_guard_cnt - GW'(1);
                end
            end
            S_HOLD: begin
                if (!bus.enable) begin
                    w_state_next = S_IDLE;
                    w_grant_next = '0;
                    w_last_next  = r_s_mux;
                end else if (!bus.req[r_s_mux] || r_dwell_cnt <= DWELL_W'(1)) begin
                    w_last_next = r_s_mux;
                    if (w_found) begin
                        w_arb = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                        w_grant_next = '0;
                    end
                end else begin
                    w_dwell_next = r_dwell_cnt - DWELL_W'(1);
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_grant_next = '0;
            end
        endcase

        // A win always passes through GUARD, even when the same requester
        // wins again, so path_valid drops for at least GUARD_CYC cycles.
        if (w_arb) begin
            w_state_next   = S_GUARD;
            w_s_mux_next   = w_winner;
            w_s_demux_next = w_dest_sel;
            w_grant_next   = 8'(8'd1 << w_winner);
            w_dwell_next   = w_dwell_load;
            w_guard_next   = GW'(GUARD_CYC);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_last      <= 3'd7;
            r_s_mux     <= '0;
            r_s_demux   <= '0;
            r_grant     <= '0;
            r_dwell_cnt <= '0;
            r_guard_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_last      <= w_last_next;
            r_s_mux     <= w_s_mux_next;
            r_s_demux   <= w_s_demux_next;
            r_grant     <= w_grant_next;
            r_dwell_cnt <= w_dwell_next;
            r_guard_cnt <= w_guard_next;
        end
    end

    assign bus.s_mux      = r_s_mux;
    assign bus.s_demux    = r_s_demux;
    assign bus.grant      = r_grant;
    assign bus.path_valid = (r_state == S_HOLD);
endmodule

// File: tb/tb_mux_path_scheduler.sv
// ---------------------------------------------------------------------------
// tb_mux_path_scheduler
// Scoreboarded bench for mux_path_scheduler (GUARD_CYC = 1). Each expected
// hold (grant, selects, length, preceding low gap) is queued when stimulus is
// applied; a monitor pops and compares one entry per observed hold.
// ---------------------------------------------------------------------------
module tb_mux_path_scheduler;
    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    mux_path_scheduler_if #(.DWELL_W(16)) bus ();

    mux_path_scheduler #(
        .DWELL_W  (16),
        .GUARD_CYC(1)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [7:0] grant;
        logic [2:0] mux;
        logic [1:0] demux;
        int         len;
        int         gap;   // 0 = gap not checked
    } hold_t;

    hold_t sb_q[$];

    task automatic expect_hold(input logic [7:0] g, input logic [2:0] m,
                               input logic [1:0] d, input int len, input int gap);
        hold_t e;
        e.grant = g;
        e.mux   = m;
        e.demux = d;
        e.len   = len;
        e.gap   = gap;
        sb_q.push_back(e);
    endtask

    // Monitor: samples on the falling edge, one transaction per hold.
    bit         in_hold = 1'b0;
    int         hold_len;
    int         gap_cnt = 0;
    int         start_gap;
    logic [7:0] m_grant;
    logic [2:0] m_mux;
    logic [1:0] m_demux;
    bit         sel_moved;
    hold_t      m_exp;

    always @(negedge clk) begin
        if (!reset_n) begin
            in_hold = 1'b0;
            gap_cnt = 0;
        end else if (bus.path_valid) begin
            if (!in_hold) begin
                in_hold   = 1'b1;
                hold_len  = 1;
                start_gap = gap_cnt;
                m_grant   = bus.grant;
                m_mux     = bus.s_mux;
                m_demux   = bus.s_demux;
                sel_moved = 1'b0;
            end else begin
                hold_len++;
                if (bus.grant !== m_grant || bus.s_mux !== m_mux || bus.s_demux !== m_demux)
                    sel_moved = 1'b1;
            end
        end else if (in_hold) begin
            in_hold = 1'b0;
            gap_cnt = 1;
            $display("hold grant=%02h s_mux=%0d s_demux=%0d len=%0d gap=%0d",
                     m_grant, m_mux, m_demux, hold_len, start_gap);
            chk("sb_expected", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                m_exp = sb_q.pop_front();
                chk("hold_grant",   32'(m_grant),   32'(m_exp.grant));
                chk("hold_s_mux",   32'(m_mux),     32'(m_exp.mux));
                chk("hold_s_demux", 32'(m_demux),   32'(m_exp.demux));
                chk("hold_len",     32'(hold_len),  32'(m_exp.len));
                chk("hold_sel_stable", 32'(sel_moved), 32'd0);
                if (m_exp.gap != 0)
                    chk("hold_gap", 32'(start_gap), 32'(m_exp.gap));
            end
        end else begin
            gap_cnt++;
        end
    end

    // Inputs change 1 time unit after the falling edge, after the monitor.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        bus.enable = 1'b0;
        bus.req    = '0;
        repeat (2) step();
        reset_n = 1'b1;
        step();
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) step();
        chk("drain_empty", 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n    = 1'b0;
        bus.enable = 1'b0;
        bus.req    = '0;
        bus.dest   = '0;
        bus.dwell  = '0;
        repeat (2) step();
        chk("rst_grant",   32'(bus.grant),      32'd0);
        chk("rst_s_mux",   32'(bus.s_mux),      32'd0);
        chk("rst_s_demux", 32'(bus.s_demux),    32'd0);
        chk("rst_pvalid",  32'(bus.path_valid), 32'd0);
        reset_n = 1'b1;
        step();

        // Single request, requester 3 to destination 3, dwell 4.
        bus.dest   = 16'h00C0;
        bus.dwell  = 16'd4;
        bus.enable = 1'b1;
        bus.req    = 8'h08;
        expect_hold(8'h08, 3'd3, 2'd3, 4, 0);
        expect_hold(8'h08, 3'd3, 2'd3, 4, 1);
        step();
        chk("t1_grant",   32'(bus.grant),      32'h08);
        chk("t1_s_mux",   32'(bus.s_mux),      32'd3);
        chk("t1_s_demux", 32'(bus.s_demux),    32'd3);
        chk("t1_pvalid",  32'(bus.path_valid), 32'd0);
        drain(60);
        bus.req = '0;
        step();
        chk("t1_idle_grant", 32'(bus.grant), 32'd0);

        // Round robin between requesters 0 and 7.
        do_reset();
        bus.dest   = 16'h8001;
        bus.dwell  = 16'd2;
        bus.enable = 1'b1;
        bus.req    = 8'h81;
        expect_hold(8'h01, 3'd0, 2'd1, 2, 0);
        expect_hold(8'h80, 3'd7, 2'd2, 2, 1);
        expect_hold(8'h01, 3'd0, 2'd1, 2, 1);
        expect_hold(8'h80, 3'd7, 2'd2, 2, 1);
        drain(60);
        bus.req = '0;
        step();

        // Early release on the third HOLD cycle hands over on that edge.
        do_reset();
        bus.dest   = 16'h0038;
        bus.dwell  = 16'd100;
        bus.enable = 1'b1;
        bus.req    = 8'h06;
        expect_hold(8'h02, 3'd1, 2'd2, 3, 0);
        expect_hold(8'h04, 3'd2, 2'd3, 3, 1);
        repeat (4) step();
        bus.req   = 8'h04;
        bus.dwell = 16'd3;
        step();
        chk("t3_next_grant", 32'(bus.grant),      32'h04);
        chk("t3_pvalid",     32'(bus.path_valid), 32'd0);
        drain(60);
        bus.req = '0;
        step();

        // Dwell of zero behaves as one.
        do_reset();
        bus.dest   = 16'h0000;
        bus.dwell  = 16'd0;
        bus.enable = 1'b1;
        bus.req    = 8'h01;
        expect_hold(8'h01, 3'd0, 2'd0, 1, 0);
        expect_hold(8'h01, 3'd0, 2'd0, 1, 1);
        drain(60);
        bus.req = '0;
        step();

        // Enable abort mid-HOLD, then resume from last+1.
        do_reset();
        bus.dest   = 16'h0900;
        bus.dwell  = 16'd10;
        bus.enable = 1'b1;
        bus.req    = 8'h30;
        expect_hold(8'h10, 3'd4, 2'd1, 2, 0);
        repeat (3) step();
        bus.enable = 1'b0;
        step();
        chk("t4_abort_grant",   32'(bus.grant),      32'd0);
        chk("t4_abort_pvalid",  32'(bus.path_valid), 32'd0);
        chk("t4_abort_s_mux",   32'(bus.s_mux),      32'd4);
        chk("t4_abort_s_demux", 32'(bus.s_demux),    32'd1);
        repeat (3) step();
        chk("t4_still_idle", 32'(bus.grant), 32'd0);
        bus.dwell  = 16'd2;
        expect_hold(8'h20, 3'd5, 2'd2, 2, 0);
        bus.enable = 1'b1;
        step();
        chk("t4_resume_grant", 32'(bus.grant), 32'h20);
        drain(60);
        bus.req = '0;
        step();

        // dest/dwell changes after arbitration wait for the next grant.
        do_reset();
        bus.dest   = 16'h0002;
        bus.dwell  = 16'd3;
        bus.enable = 1'b1;
        bus.req    = 8'h01;
        expect_hold(8'h01, 3'd0, 2'd2, 3, 0);
        expect_hold(8'h01, 3'd0, 2'd1, 8, 1);
        step();
        bus.dest  = 16'h0001;
        bus.dwell = 16'd8;
        step();
        chk("t5_demux_held", 32'(bus.s_demux), 32'd2);
        drain(100);
        bus.req = '0;
        step();

        // Asynchronous reset in the middle of a hold.
        do_reset();
        bus.dest   = 16'h3009;
        bus.dwell  = 16'd5;
        bus.enable = 1'b1;
        bus.req    = 8'h40;
        repeat (3) step();
        chk("t6_pre_pvalid", 32'(bus.path_valid), 32'd1);
        chk("t6_pre_s_mux",  32'(bus.s_mux),      32'd6);
        reset_n = 1'b0;
        #2;
        chk("t6_async_grant",   32'(bus.grant),      32'd0);
        chk("t6_async_s_mux",   32'(bus.s_mux),      32'd0);
        chk("t6_async_s_demux", 32'(bus.s_demux),    32'd0);
        chk("t6_async_pvalid",  32'(bus.path_valid), 32'd0);
        bus.req   = 8'hFF;
        bus.dwell = 16'd1;
        step();
        step();
        reset_n = 1'b1;
        expect_hold(8'h01, 3'd0, 2'd1, 1, 0);
        expect_hold(8'h02, 3'd1, 2'd2, 1, 1);
        step();
        chk("t6_first_grant", 32'(bus.grant), 32'h01);
        drain(60);
        bus.req = '0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
